// File: rtl/fir_pkg.sv
// Shared constants, serializer states and beat/word helpers for the FIR output path.
package fir_pkg;

  localparam int unsigned PIX_W          = 24;
  localparam int unsigned LANES          = 4;
  localparam int unsigned BEAT_W         = PIX_W * LANES;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_BEAT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2,
    W2   = 2'd3
  } ser_state_t;

  function automatic logic [WORD_W-1:0] beat_word(input logic [BEAT_W-1:0] beat,
                                                  input logic [1:0]        idx);
    logic [WORD_W-1:0] w;
    w = '0;
    case (idx)
      2'd0:    w = beat[31:0];
      2'd1:    w = beat[63:32];
      2'd2:    w = beat[95:64];
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fir_beat_fifo.sv
// Single-clock show-ahead FIFO; dout always presents the head entry.
module fir_beat_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_packer.sv
// Buffers 96-bit filter beats and serializes each into three 32-bit DMA words,
// with per-frame beat counting and sticky overflow reporting.
module fir_out_packer
  import fir_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tc_set,
  input  logic [CNT_W-1:0]       frame_len,
  input  logic                   valid_core,
  input  logic [PIX_W-1:0]       output_data1,
  input  logic [PIX_W-1:0]       output_data2,
  input  logic [PIX_W-1:0]       output_data3,
  input  logic [PIX_W-1:0]       output_data4,
  output logic [WORD_W-1:0]      wr_data,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic                   frame_done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  // rst_n keeps its legacy name but is active-high.
  logic              rst;
  ser_state_t        state_q;
  logic [BEAT_W-1:0] beat_in;
  logic [BEAT_W-1:0] head;
  logic [BEAT_W-1:0] hold_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop_en;
  logic              push_en;
  logic              drop;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  frame_len_q;
  logic [CNT_W-1:0]  cnt_next;

  assign rst      = rst_n;
  assign beat_in  = {output_data4, output_data3, output_data2, output_data1};
  assign cnt_next = beat_cnt + CNT_W'(1);

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    pop_en  = 1'b0;
    push_en = 1'b0;
    drop    = 1'b0;
    if (!rst && !tc_set) begin
      pop_en  = !fifo_empty && ((state_q == IDLE) || (state_q == W2 && wr_ready));
      push_en = valid_core && (!fifo_full || pop_en);
      drop    = valid_core && fifo_full && !pop_en;
    end
  end

  fir_beat_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BEAT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (tc_set),
    .push  (push_en),
    .pop   (pop_en),
    .din   (beat_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst || tc_set) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      wr_valid    <= 1'b0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      beat_cnt    <= '0;
      frame_len_q <= rst ? '0 : frame_len;
    end else begin
      frame_done <= 1'b0;
      if (drop) overflow <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pop_en) begin
            hold_q   <= head;
            wr_data  <= beat_word(head, 2'd0);
            wr_valid <= 1'b1;
            state_q  <= W0;
          end
        end
        W0: begin
          if (wr_ready) begin
            wr_data <= beat_word(hold_q, 2'd1);
            state_q <= W1;
          end
        end
        W1: begin
          if (wr_ready) begin
            wr_data <= beat_word(hold_q, 2'd2);
            state_q <= W2;
          end
        end
        W2: begin
          if (wr_ready) begin
            if (frame_len_q != '0 && cnt_next == frame_len_q) begin
              frame_done <= 1'b1;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= cnt_next;
            end
            if (pop_en) begin
              hold_q  <= head;
              wr_data <= beat_word(head, 2'd0);
              state_q <= W0;
            end else begin
              wr_valid <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
